ysyx_22040237_rv_multi_cyc_ctrl: RTL and testbench
==================================================

YSYX_22040237_RV_MULTI_CYC_CTRL -- requirements
Module: ysyx_22040237_rv_multi_cyc_ctrl

Interface
REQ-001 SHALL take parameters, one per line:
  XLEN, 64, datapath/PC width (32 or 64).
  RESET_PC, 64'h8000_0000 (truncated to XLEN), PC value after reset.
  TIMEOUT_CYC, 255, max wait cycles in any memory-wait state (1..65535).
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous active-low reset.
  imem_req_valid  out  1  fetch request.
  imem_req_ready  in  1  fetch accepted.
  imem_addr  out  XLEN  fetch address (= pc).
  imem_rsp_valid  in  1  fetch data valid.
  imem_rsp_data  in  32  fetched instruction.
  imem_rsp_err  in  1  fetch bus error, qualified by imem_rsp_valid.
  inst  out  32  latched instruction for the decoder.
  pc  out  XLEN  current PC.
  dec_ebreak  in  1  decoder flags ebreak.
  dec_is_load  in  1  decoder flags load.
  dec_is_store  in  1  decoder flags store.
  dec_rd_w_en  in  1  decoder requests rd write.
  exu_next_pc  in  XLEN  branch/jump target.
  exu_pc_sel  in  1  1 = take exu_next_pc, 0 = pc+4.
  dmem_req_valid  out  1  data request.
  dmem_req_ready  in  1  data request accepted.
  dmem_we  out  1  1 = store.
  dmem_rsp_valid  in  1  load data valid.
  dmem_rsp_data  in  XLEN  load data.
  load_data  out  XLEN  latched load result for writeback mux.
  rf_we  out  1  register-file write strobe.
  halted  out  1  core stopped.
  halt_cause  out  2  0 = ebreak, 1 = fetch error, 2 = misaligned PC, 3 = timeout.
  cycle_cnt  out  XLEN  cycles since reset.
  instret_cnt  out  XLEN  retired instructions.

Function
REQ-003 SHALL implement FSM states IF, IWAIT, EX, MEM, MWAIT, WB, HALT.
REQ-004 IF SHALL assert imem_req_valid with imem_addr = pc, hold both stable until imem_req_ready, then enter IWAIT.
REQ-005 IWAIT SHALL, on imem_rsp_valid with imem_rsp_err = 0, register imem_rsp_data into inst and enter EX; with imem_rsp_err = 1, enter HALT with cause 1.
REQ-006 EX SHALL last exactly one cycle, with the decoder and exu combinational on inst; next state is HALT (cause 0) if dec_ebreak, MEM if dec_is_load or dec_is_store, otherwise WB.
REQ-007 MEM SHALL assert dmem_req_valid with dmem_we = dec_is_store until dmem_req_ready; then go to MWAIT for a load, WB for a store.
REQ-008 MWAIT SHALL register dmem_rsp_data into load_data on dmem_rsp_valid and enter WB.
REQ-009 WB SHALL last one cycle:
  rf_we = dec_rd_w_en for that cycle only.
  pc <= exu_pc_sel ? exu_next_pc : pc+4, modulo 2^XLEN.
  instret_cnt increments by 1.
  next state is IF.
REQ-010 If the selected next PC has bits [1:0] != 0, WB SHALL leave pc unchanged, increment instret_cnt, and enter HALT with cause 2.
REQ-011 A wait counter SHALL clear on entry to IF, IWAIT, MEM and MWAIT and increment each cycle spent waiting there; when it reaches TIMEOUT_CYC, the next state SHALL be HALT with cause 3.
REQ-012 HALT SHALL be absorbing until reset:
  halted = 1.
  halt_cause frozen.
  every request output and rf_we = 0.
  cycle_cnt frozen.
REQ-013 cycle_cnt SHALL increment every non-HALT cycle and wrap at 2^XLEN; instret_cnt SHALL wrap likewise.
REQ-014 imem_req_valid, dmem_req_valid and rf_we SHALL be Moore outputs decoded from the state register only.

Reset
REQ-015 While rst = 0, asynchronously:
  state = IF, pc = RESET_PC.
  inst = 32'h0000_0013 (nop), load_data = 0.
  halted = 0, halt_cause = 0.
  cycle_cnt = 0, instret_cnt = 0, wait counter = 0.
REQ-016 Reset asserted mid-transaction SHALL drop all requests immediately; after release, the first action SHALL be a fetch at RESET_PC; late responses arriving in IF SHALL be ignored.

Structure
REQ-017 State encodings, halt_cause codes and the nop constant SHALL live in a shared package ysyx_22040237_rv_pkg.
REQ-018 The wait/timeout counter SHALL be the sub-module ysyx_22040237_wait_timer (clear, enable, limit, expired); everything else is flat.

Verification
REQ-019 Zero-wait memory model, addi at RESET_PC -> imem_addr = RESET_PC, rf_we pulses once in WB, pc = RESET_PC+4, instret_cnt = 1 after 4 cycles (IF, IWAIT, EX, WB).
REQ-020 Load with dmem_req_ready delayed 3 cycles and rsp 2 cycles later, data 0x1234 -> load_data = 0x1234 before WB; dmem_req_valid held steady for 4 cycles.
REQ-021 Jump, exu_pc_sel = 1, exu_next_pc = RESET_PC+0x100 -> next imem_addr = RESET_PC+0x100; with exu_next_pc = RESET_PC+0x102 -> halted = 1, halt_cause = 2, pc unchanged.
REQ-022 ebreak fetched as the third instruction -> halted = 1, halt_cause = 0, instret_cnt = 2, cycle_cnt frozen thereafter.
REQ-023 imem_req_ready held 0 with TIMEOUT_CYC = 8 -> halted = 1, halt_cause = 3 after 8 wait cycles; imem_rsp_err = 1 -> halt_cause = 1.
REQ-024 rst pulsed low during MWAIT, with the response arriving after release -> response ignored, fetch at RESET_PC, all counters 0.

Source files
------------

// File: rtl/ysyx_22040237_rv_pkg.sv
// ysyx_22040237_rv_pkg
//   Types and constants shared by the multi-cycle control unit and its
//   wait timer: FSM state encoding, halt cause codes, the nop used as the
//   post-reset instruction, and the wait counter width.
package ysyx_22040237_rv_pkg;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_MWAIT = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    HC_EBREAK    = 2'd0,
    HC_FETCH_ERR = 2'd1,
    HC_MISALIGN  = 2'd2,
    HC_TIMEOUT   = 2'd3
  } halt_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Wide enough for the largest allowed timeout limit (65535).
  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/ysyx_22040237_wait_timer.sv
// ysyx_22040237_wait_timer
//   Counts consecutive cycles spent waiting on a bus handshake and flags
//   the cycle in which the count would reach the limit.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, count -> 0
//   clear    force count to 0 next cycle (takes priority over enable)
//   enable   this cycle is a wait cycle; count advances by one
//   limit    number of wait cycles allowed before expiry
//   expired  this wait cycle is the limit-th one; owner should give up
module ysyx_22040237_wait_timer
  import ysyx_22040237_rv_pkg::*;
#(
  parameter int unsigned W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_inc;

  // One bit wider so the compare cannot alias when count_q is all ones.
  assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc[W-1:0];
    end
  end

  // Compare against the incremented value so expiry coincides with the
  // cycle that would bring the count up to the limit.
  assign expired = enable && !clear && (count_inc == {1'b0, limit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ysyx_22040237_rv_multi_cyc_ctrl.sv
// ysyx_22040237_rv_multi_cyc_ctrl
//   Multi-cycle sequencing for a simple RISC-V core: fetch, execute,
//   optional data access, writeback. Holds pc, the fetched instruction,
//   the load result and the cycle / retired-instruction counters.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   imem_*                instruction fetch request / response
//   inst, pc              latched instruction and current pc for decode/exu
//   dec_*                 decoder flags, combinational on inst
//   exu_next_pc/pc_sel    branch/jump target and select
//   dmem_*                data request / load response
//   load_data, rf_we      writeback data and write strobe
//   halted, halt_cause    stop indication (0 ebreak, 1 fetch err,
//                         2 misaligned pc, 3 timeout)
//   cycle_cnt, instret_cnt performance counters
//
// state  | meaning
// -------+-----------------------------------------------------------
// IF     | fetch request at pc, waiting for imem_req_ready
// IWAIT  | waiting for fetch response, latch inst
// EX     | one cycle, decoder/exu settle on inst, pick the next step
// MEM    | data request, waiting for dmem_req_ready
// MWAIT  | waiting for load response, latch load_data
// WB     | one cycle, rf write strobe, pc update, retire
// HALT   | absorbing until reset
module ysyx_22040237_rv_multi_cyc_ctrl
  import ysyx_22040237_rv_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  input  logic            dec_ebreak,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_rd_w_en,
  input  logic [XLEN-1:0] exu_next_pc,
  input  logic            exu_pc_sel,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_data,
  output logic [XLEN-1:0] load_data,
  output logic            rf_we,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  localparam logic [XLEN-1:0]       RST_PC     = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0]       PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0]       CNT_ONE    = XLEN'(1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYC);

  state_e          state_q,       state_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic [31:0]     inst_q,        inst_d;
  logic [XLEN-1:0] load_data_q,   load_data_d;
  halt_cause_e     halt_cause_q,  halt_cause_d;
  logic [XLEN-1:0] cycle_cnt_q,   cycle_cnt_d;
  logic [XLEN-1:0] instret_cnt_q, instret_cnt_d;

  logic            wait_en;
  logic            wait_clr;
  logic            wait_expired;
  logic [XLEN-1:0] next_pc;

  // A wait cycle is one where the current state is held by a missing
  // handshake. Any other cycle clears the timer, so every wait state is
  // entered with a zero count.
  always_comb begin
    wait_en = 1'b0;
    case (state_q)
      ST_IF:    wait_en = !imem_req_ready;
      ST_IWAIT: wait_en = !imem_rsp_valid;
      ST_MEM:   wait_en = !dmem_req_ready;
      ST_MWAIT: wait_en = !dmem_rsp_valid;
      default:  wait_en = 1'b0;
    endcase
  end

  assign wait_clr = !wait_en;

  ysyx_22040237_wait_timer #(
    .W (WAIT_CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (wait_clr),
    .enable  (wait_en),
    .limit   (WAIT_LIMIT),
    .expired (wait_expired)
  );

  assign next_pc = exu_pc_sel ? exu_next_pc : (pc_q + PC_STEP);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    load_data_d   = load_data_q;
    halt_cause_d  = halt_cause_q;
    instret_cnt_d = instret_cnt_q;
    cycle_cnt_d   = (state_q == ST_HALT) ? cycle_cnt_q : (cycle_cnt_q + CNT_ONE);

    case (state_q)
      ST_IF: begin
        if (imem_req_ready) begin
          state_d = ST_IWAIT;
        end else if (wait_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_TIMEOUT;
        end
      end
      ST_IWAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d      = ST_HALT;
            halt_cause_d = HC_FETCH_ERR;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = ST_EX;
          end
        end else if (wait_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_TIMEOUT;
        end
      end
      ST_EX: begin
        if (dec_ebreak) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_EBREAK;
        end else if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_req_ready) begin
          state_d = dec_is_store ? ST_WB : ST_MWAIT;
        end else if (wait_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_TIMEOUT;
        end
      end
      ST_MWAIT: begin
        if (dmem_rsp_valid) begin
          load_data_d = dmem_rsp_data;
          state_d     = ST_WB;
        end else if (wait_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_TIMEOUT;
        end
      end
      ST_WB: begin
        // The instruction retires even when its target is misaligned;
        // only the pc update is suppressed.
        instret_cnt_d = instret_cnt_q + CNT_ONE;
        if (next_pc[1:0] != 2'b00) begin
          state_d      = ST_HALT;
          halt_cause_d = HC_MISALIGN;
        end else begin
          pc_d    = next_pc;
          state_d = ST_IF;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IF;
      pc_q          <= RST_PC;
      inst_q        <= INST_NOP;
      load_data_q   <= '0;
      halt_cause_q  <= HC_EBREAK;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      load_data_q   <= load_data_d;
      halt_cause_q  <= halt_cause_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign imem_req_valid = (state_q == ST_IF);
  assign imem_addr      = pc_q;
  assign dmem_req_valid = (state_q == ST_MEM);
  assign dmem_we        = (state_q == ST_MEM) && dec_is_store;
  assign rf_we          = (state_q == ST_WB) && dec_rd_w_en;
  assign halted         = (state_q == ST_HALT);
  assign halt_cause     = halt_cause_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign load_data      = load_data_q;
  assign cycle_cnt      = cycle_cnt_q;
  assign instret_cnt    = instret_cnt_q;

endmodule

// File: tb/tb_ysyx_22040237_rv_multi_cyc_ctrl.sv
module tb_ysyx_22040237_rv_multi_cyc_ctrl;

  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int          TMO    = 8;

  localparam int K_ALU    = 0;
  localparam int K_LOAD   = 1;
  localparam int K_STORE  = 2;
  localparam int K_JUMP   = 3;
  localparam int K_EBREAK = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [63:0]     imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic [31:0]     inst;
  logic [63:0]     pc;
  logic            dec_ebreak;
  logic            dec_is_load;
  logic            dec_is_store;
  logic            dec_rd_w_en;
  logic [63:0]     exu_next_pc;
  logic            exu_pc_sel;
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_we;
  logic            dmem_rsp_valid;
  logic [63:0]     dmem_rsp_data;
  logic [63:0]     load_data;
  logic            rf_we;
  logic            halted;
  logic [1:0]      halt_cause;
  logic [63:0]     cycle_cnt;
  logic [63:0]     instret_cnt;

  int total = 0;
  int bad   = 0;

  // Architectural reference: pc, retired count, cycles since reset, halted.
  logic [63:0] m_pc;
  logic [63:0] m_instret;
  logic [63:0] exp_cyc;
  logic        m_halted;

  always #5 clk = ~clk;

  ysyx_22040237_rv_multi_cyc_ctrl #(
    .XLEN        (XLEN),
    .RESET_PC    (RST_PC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst           (inst),
    .pc             (pc),
    .dec_ebreak     (dec_ebreak),
    .dec_is_load    (dec_is_load),
    .dec_is_store   (dec_is_store),
    .dec_rd_w_en    (dec_rd_w_en),
    .exu_next_pc    (exu_next_pc),
    .exu_pc_sel     (exu_pc_sel),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .load_data      (load_data),
    .rf_we          (rf_we),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  // One clock; a cycle counts toward cycle_cnt unless the core is halted.
  task automatic step();
    if (!m_halted) exp_cyc = exp_cyc + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = '0;
    dec_ebreak     = 1'b0;
    dec_is_load    = 1'b0;
    dec_is_store   = 1'b0;
    dec_rd_w_en    = 1'b0;
    exu_pc_sel     = 1'b0;
    exu_next_pc    = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (pc !== RST_PC || inst !== 32'h0000_0013 || load_data !== 64'd0 || halted !== 1'b0 ||
        halt_cause !== 2'd0 || cycle_cnt !== 64'd0 || instret_cnt !== 64'd0 ||
        dmem_req_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: pc=%h inst=%h ld=%h halted=%b cause=%0d cyc=%0d ret=%0d dreq=%b rf_we=%b want pc=%h inst=00000013 rest 0",
               pc, inst, load_data, halted, halt_cause, cycle_cnt, instret_cnt, dmem_req_valid, rf_we, RST_PC);
    end
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    m_pc      = RST_PC;
    m_instret = 64'd0;
    m_halted  = 1'b0;
    exp_cyc   = 64'd0;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL reset_fetch: valid=%b addr=%h want valid=1 addr=%h", imem_req_valid, imem_addr, RST_PC);
    end
  endtask

  // Run one instruction through the core with the given handshake delays
  // and check it against the reference model.
  task automatic do_instr(input logic [31:0] iw, input int kind, input logic rdw,
                          input logic [63:0] tgt, input logic [63:0] ldata,
                          input int il, input int rl, input int dl, input int ml);
    logic [63:0] nxt;
    nxt = (kind == K_JUMP) ? tgt : (m_pc + 64'd4);

    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
      bad++;
      $display("FAIL if_req: valid=%b addr=%h want valid=1 addr=%h", imem_req_valid, imem_addr, m_pc);
    end
    for (int i = 0; i < il; i++) begin
      imem_req_ready = 1'b0;
      step();
      total++;
      if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
        bad++;
        $display("FAIL if_hold: valid=%b addr=%h want valid=1 addr=%h", imem_req_valid, imem_addr, m_pc);
      end
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;

    total++;
    if (imem_req_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL iwait_state: ireq=%b halted=%b want 0 0", imem_req_valid, halted);
    end
    repeat (rl) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = iw;
    dec_ebreak     = (kind == K_EBREAK);
    dec_is_load    = (kind == K_LOAD);
    dec_is_store   = (kind == K_STORE);
    dec_rd_w_en    = rdw;
    exu_pc_sel     = (kind == K_JUMP);
    exu_next_pc    = (kind == K_JUMP) ? tgt : ({$urandom, $urandom} | 64'h1);
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;

    total++;
    if (inst !== iw || rf_we !== 1'b0 || dmem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL ex_inst: inst=%h rf_we=%b dreq=%b want inst=%h 0 0", inst, rf_we, dmem_req_valid, iw);
    end

    if (kind == K_EBREAK) begin
      step();
      m_halted = 1'b1;
      total++;
      if (halted !== 1'b1 || halt_cause !== 2'd0 || instret_cnt !== m_instret || pc !== m_pc) begin
        bad++;
        $display("FAIL ebreak_halt: halted=%b cause=%0d ret=%0d pc=%h want 1 0 %0d %h",
                 halted, halt_cause, instret_cnt, pc, m_instret, m_pc);
      end
      return;
    end
    step();

    if (kind == K_LOAD || kind == K_STORE) begin
      for (int i = 0; i <= dl; i++) begin
        total++;
        if (dmem_req_valid !== 1'b1 || dmem_we !== (kind == K_STORE)) begin
          bad++;
          $display("FAIL mem_req: valid=%b we=%b want valid=1 we=%b", dmem_req_valid, dmem_we, (kind == K_STORE));
        end
        dmem_req_ready = (i == dl);
        step();
      end
      dmem_req_ready = 1'b0;
      if (kind == K_LOAD) begin
        repeat (ml) step();
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = ldata;
        step();
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = {$urandom, $urandom};
        total++;
        if (load_data !== ldata) begin
          bad++;
          $display("FAIL load_data: got=%h want=%h", load_data, ldata);
        end
      end
    end

    total++;
    if (rf_we !== rdw || dmem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL wb_rf_we: rf_we=%b dreq=%b want rf_we=%b dreq=0", rf_we, dmem_req_valid, rdw);
    end
    step();
    m_instret = m_instret + 64'd1;

    if (nxt[1:0] != 2'b00) begin
      m_halted = 1'b1;
      total++;
      if (halted !== 1'b1 || halt_cause !== 2'd2 || pc !== m_pc) begin
        bad++;
        $display("FAIL misalign_halt: halted=%b cause=%0d pc=%h want 1 2 %h", halted, halt_cause, pc, m_pc);
      end
    end else begin
      m_pc = nxt;
      total++;
      if (halted !== 1'b0 || pc !== m_pc || rf_we !== 1'b0) begin
        bad++;
        $display("FAIL wb_pc: halted=%b pc=%h rf_we=%b want 0 %h 0", halted, pc, rf_we, m_pc);
      end
    end
    total++;
    if (instret_cnt !== m_instret || cycle_cnt !== exp_cyc) begin
      bad++;
      $display("FAIL counters: ret=%0d cyc=%0d want ret=%0d cyc=%0d", instret_cnt, cycle_cnt, m_instret, exp_cyc);
    end
  endtask

  // Halted core must ignore every input and keep all its outputs frozen.
  task automatic chk_frozen(input logic [1:0] cause);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b1;
    dec_rd_w_en    = 1'b1;
    repeat (4) step();
    total++;
    if (halted !== 1'b1 || halt_cause !== cause || cycle_cnt !== exp_cyc || imem_req_valid !== 1'b0 ||
        dmem_req_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++;
      $display("FAIL halt_frozen: halted=%b cause=%0d cyc=%0d ireq=%b dreq=%b rf_we=%b want 1 %0d %0d 0 0 0",
               halted, halt_cause, cycle_cnt, imem_req_valid, dmem_req_valid, rf_we, cause, exp_cyc);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_addi_zero_wait();
    do_reset();
    do_instr(32'h0010_0093, K_ALU, 1'b1, 64'd0, 64'd0, 0, 0, 0, 0);
    total++;
    if (pc !== RST_PC + 64'd4 || instret_cnt !== 64'd1 || cycle_cnt !== 64'd4) begin
      bad++;
      $display("FAIL addi_zero_wait: pc=%h ret=%0d cyc=%0d want %h 1 4", pc, instret_cnt, cycle_cnt, RST_PC + 64'd4);
    end
  endtask

  task automatic test_load_delayed();
    do_reset();
    do_instr(32'h0000_3083, K_LOAD, 1'b1, 64'd0, 64'h1234, 0, 0, 3, 2);
  endtask

  task automatic test_jump();
    do_reset();
    do_instr(32'h1000_00ef, K_JUMP, 1'b1, RST_PC + 64'h100, 64'd0, 1, 1, 0, 0);
    do_instr(32'h0020_00ef, K_JUMP, 1'b1, RST_PC + 64'h102, 64'd0, 0, 2, 0, 0);
    total++;
    if (pc !== RST_PC + 64'h100 || halt_cause !== 2'd2) begin
      bad++;
      $display("FAIL jump_misalign_pc: pc=%h cause=%0d want %h 2", pc, halt_cause, RST_PC + 64'h100);
    end
    chk_frozen(2'd2);
  endtask

  task automatic test_ebreak_third();
    do_reset();
    do_instr(32'h0010_0093, K_ALU, 1'b1, 64'd0, 64'd0, 2, 1, 0, 0);
    do_instr(32'h0010_3023, K_STORE, 1'b0, 64'd0, 64'd0, 0, 0, 2, 0);
    do_instr(32'h0010_0073, K_EBREAK, 1'b0, 64'd0, 64'd0, 1, 0, 0, 0);
    total++;
    if (instret_cnt !== 64'd2) begin
      bad++;
      $display("FAIL ebreak_instret: got=%0d want=2", instret_cnt);
    end
    chk_frozen(2'd0);
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TMO - 1) step();
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL tmo_if_early: halted=%b want 0", halted);
    end
    step();
    m_halted = 1'b1;
    total++;
    if (halted !== 1'b1 || halt_cause !== 2'd3 || cycle_cnt !== 64'd8) begin
      bad++;
      $display("FAIL tmo_if: halted=%b cause=%0d cyc=%0d want 1 3 8", halted, halt_cause, cycle_cnt);
    end
    chk_frozen(2'd3);

    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    repeat (TMO - 1) step();
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL tmo_iwait_early: halted=%b want 0", halted);
    end
    step();
    m_halted = 1'b1;
    total++;
    if (halted !== 1'b1 || halt_cause !== 2'd3) begin
      bad++;
      $display("FAIL tmo_iwait: halted=%b cause=%0d want 1 3", halted, halt_cause);
    end
  endtask

  task automatic test_fetch_err();
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    m_halted = 1'b1;
    total++;
    if (halted !== 1'b1 || halt_cause !== 2'd1 || inst !== 32'h0000_0013 || instret_cnt !== 64'd0) begin
      bad++;
      $display("FAIL fetch_err: halted=%b cause=%0d inst=%h ret=%0d want 1 1 00000013 0",
               halted, halt_cause, inst, instret_cnt);
    end
    chk_frozen(2'd1);
  endtask

  task automatic test_reset_mwait();
    do_reset();
    do_instr(32'h0010_0093, K_ALU, 1'b1, 64'd0, 64'd0, 0, 0, 0, 0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_3083;
    dec_is_load    = 1'b1;
    dec_rd_w_en    = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    step();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    step();
    do_reset();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 64'hdead_beef_cafe_f00d;
    imem_rsp_valid = 1'b1;
    imem_rsp_err   = 1'b1;
    step();
    clear_inputs();
    total++;
    if (load_data !== 64'd0 || halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RST_PC ||
        inst !== 32'h0000_0013 || cycle_cnt !== 64'd1 || instret_cnt !== 64'd0) begin
      bad++;
      $display("FAIL late_rsp_ignored: ld=%h halted=%b ireq=%b addr=%h inst=%h cyc=%0d ret=%0d want 0 0 1 %h 00000013 1 0",
               load_data, halted, imem_req_valid, imem_addr, inst, cycle_cnt, instret_cnt, RST_PC);
    end
    do_instr(32'h0020_0113, K_ALU, 1'b1, 64'd0, 64'd0, 0, 1, 0, 0);
  endtask

  task automatic test_random_prog();
    do_reset();
    for (int n = 0; n < 30; n++) begin
      int          k;
      logic [63:0] t;
      k = int'($urandom_range(0, 3));
      t = RST_PC + (64'($urandom_range(0, 1023)) << 2);
      do_instr($urandom, k, 1'($urandom_range(0, 1)), t, {$urandom, $urandom},
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    m_halted = 1'b0;
    exp_cyc = 64'd0;
    m_pc = RST_PC;
    m_instret = 64'd0;
    clear_inputs();
    #2;
    test_reset();
    test_addi_zero_wait();
    test_load_delayed();
    test_jump();
    test_ebreak_third();
    test_timeout();
    test_fetch_err();
    test_reset_mwait();
    test_random_prog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
